// File: rtl/rect_pulse_seq.sv
// Rectangular pulse-burst sequencer: DELAY once, then RISE/HIGH/FALL/LOW periods
// with slope-limited ramps, driving a registered amplitude code to a DAC.
module rect_pulse_seq #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  iv,
  input  logic [W-1:0]  pv,
  input  logic [W-1:0]  rstep,
  input  logic [W-1:0]  fstep,
  input  logic [CW-1:0] td,
  input  logic [CW-1:0] th,
  input  logic [CW-1:0] tl,
  input  logic [CW-1:0] cycles,
  output logic [W-1:0]  level,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RISE  = 3'd2,
    HIGH  = 3'd3,
    FALL  = 3'd4,
    LOW   = 3'd5
  } phase_e;

  typedef struct packed {
    phase_e        ph;
    logic [CW-1:0] cnt;
  } step_t;

  typedef struct packed {
    logic [W-1:0]  iv;
    logic [W-1:0]  pv;
    logic [W-1:0]  rstep;
    logic [W-1:0]  fstep;
    logic [CW-1:0] th;
    logic [CW-1:0] tl;
    logic          inf;
  } cfg_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // First state of a period. A flat pulse has no ramps; if HIGH and LOW are
  // both empty as well, one LOW cycle keeps the period from vanishing.
  function automatic step_t period_entry(input logic flat,
                                         input logic [CW-1:0] hold_h,
                                         input logic [CW-1:0] hold_l);
    step_t s;
    if (!flat) begin
      s.ph  = RISE;
      s.cnt = '0;
    end else if (hold_h != '0) begin
      s.ph  = HIGH;
      s.cnt = hold_h - CNT_ONE;
    end else begin
      s.ph  = LOW;
      s.cnt = (hold_l == '0) ? '0 : hold_l - CNT_ONE;
    end
    return s;
  endfunction

  phase_e        phase_q, phase_d;
  logic [W-1:0]  level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [CW-1:0] per_q,   per_d;
  cfg_t          cfg_q,   cfg_d;
  logic          done_q,  done_d;
  logic          busy_q,  busy_d;

  logic          flat_in, flat_q;
  logic [W-1:0]  pv_eff;
  logic [W:0]    rise_sum, fall_floor;
  logic [W-1:0]  rise_val, fall_val;
  logic          after_high, period_end;
  step_t         nxt;

  assign flat_in = (pv <= iv);
  assign pv_eff  = flat_in ? iv : pv;
  assign flat_q  = (cfg_q.pv == cfg_q.iv);

  // Ramp arithmetic carries one extra bit so saturation is decided before any wrap.
  assign rise_sum   = {1'b0, level_q} + {1'b0, cfg_q.rstep};
  assign fall_floor = {1'b0, cfg_q.iv} + {1'b0, cfg_q.fstep};
  assign rise_val   = (cfg_q.rstep == '0 || rise_sum >= {1'b0, cfg_q.pv})
                      ? cfg_q.pv : rise_sum[W-1:0];
  assign fall_val   = (cfg_q.fstep == '0 || {1'b0, level_q} < fall_floor)
                      ? cfg_q.iv : level_q - cfg_q.fstep;

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    phase_d    = phase_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    cfg_d      = cfg_q;
    done_d     = 1'b0;
    after_high = 1'b0;
    period_end = 1'b0;
    nxt        = period_entry(flat_q, cfg_q.th, cfg_q.tl);

    case (phase_q)
      IDLE: begin
        level_d = cfg_q.iv;
        if (start && !stop) begin
          cfg_d   = '{iv: iv, pv: pv_eff, rstep: rstep, fstep: fstep,
                      th: th, tl: tl, inf: (cycles == '0)};
          level_d = iv;
          per_d   = cycles;
          if (td != '0) begin
            phase_d = DELAY;
            cnt_d   = td - CNT_ONE;
          end else begin
            nxt     = period_entry(flat_in, th, tl);
            phase_d = nxt.ph;
            cnt_d   = nxt.cnt;
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          phase_d = nxt.ph;
          cnt_d   = nxt.cnt;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RISE: begin
        level_d = rise_val;
        if (rise_val == cfg_q.pv) begin
          if (cfg_q.th != '0) begin
            phase_d = HIGH;
            cnt_d   = cfg_q.th - CNT_ONE;
          end else begin
            after_high = 1'b1;
          end
        end
      end
      HIGH: begin
        if (cnt_q == '0) after_high = 1'b1;
        else             cnt_d      = cnt_q - CNT_ONE;
      end
      FALL: begin
        level_d = fall_val;
        if (fall_val == cfg_q.iv) begin
          if (cfg_q.tl != '0) begin
            phase_d = LOW;
            cnt_d   = cfg_q.tl - CNT_ONE;
          end else begin
            period_end = 1'b1;
          end
        end
      end
      LOW: begin
        if (cnt_q == '0) period_end = 1'b1;
        else             cnt_d      = cnt_q - CNT_ONE;
      end
      default: phase_d = IDLE;
    endcase

    if (after_high) begin
      if (!flat_q) begin
        phase_d = FALL;
      end else if (cfg_q.tl != '0) begin
        phase_d = LOW;
        cnt_d   = cfg_q.tl - CNT_ONE;
      end else begin
        period_end = 1'b1;
      end
    end

    if (period_end) begin
      if (cfg_q.inf || per_q != CNT_ONE) begin
        if (!cfg_q.inf) per_d = per_q - CNT_ONE;
        phase_d = nxt.ph;
        cnt_d   = nxt.cnt;
      end else begin
        phase_d = IDLE;
        level_d = cfg_q.iv;
        per_d   = '0;
        done_d  = 1'b1;
      end
    end

    if (stop && phase_q != IDLE) begin
      phase_d = IDLE;
      level_d = cfg_q.iv;
      cnt_d   = '0;
      per_d   = '0;
      done_d  = 1'b1;
    end

    busy_d = (phase_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign phase = phase_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/rect_pulse_seq.md
RECT_PULSE_SEQ -- requirements
Module: rect_pulse_seq

Interface
REQ-001 SHALL have parameter W, default 8, amplitude code width.
REQ-002 SHALL have parameter CW, default 16, duration/count width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request one burst; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  synchronous abort of a running burst.
REQ-007 SHALL have ports iv, pv  input  W each  initial (low) and pulse (high) level codes.
REQ-008 SHALL have ports rstep, fstep  input  W each  rise/fall slope, codes per cycle.
REQ-009 SHALL have ports td, th, tl  input  CW each  delay, high-hold and low-hold durations, in cycles.
REQ-010 SHALL have port cycles  input  CW  periods per burst; 0 = run until stop.
REQ-011 SHALL have port level  output  W  registered amplitude code to downstream source/DAC.
REQ-012 SHALL have port phase  output  3  current state: IDLE=0, DELAY=1, RISE=2, HIGH=3, FALL=4, LOW=5.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst end or abort.

Function
REQ-015 SHALL latch iv, pv, rstep, fstep, td, th, tl, cycles on the edge where start=1 in IDLE; later input changes do not affect the running burst.
REQ-016 SHALL clamp latched pv to latched iv when pv < iv, giving a flat pulse with zero-length RISE/FALL.
REQ-017 SHALL, in IDLE, hold level at the last latched iv (0 after reset).
REQ-018 SHALL, on accepted start at edge k, show busy=1 and the first non-skipped state of DELAY→RISE at cycle k+1, with level=iv.
REQ-019 SHALL hold DELAY, HIGH and LOW for exactly td, th and tl cycles respectively; a duration of 0 skips that state with no idle cycle.
REQ-020 SHALL, in RISE, add rstep to level each cycle, saturating at pv; RISE exits on the edge level reaches pv, so HIGH's first cycle shows level=pv.
REQ-021 SHALL, in FALL, subtract fstep each cycle, saturating at iv; FALL exits on the edge level reaches iv.
REQ-022 SHALL treat rstep=0 or fstep=0 as an instantaneous jump: one-cycle RISE/FALL ending at pv/iv.
REQ-023 SHALL compute ramp sums at W+1 bits so no wrap-around occurs for pv near 2^W-1 or iv near 0.
REQ-024 SHALL sequence one period as RISE→HIGH→FALL→LOW; DELAY occurs only once per burst.
REQ-025 SHALL, at the end of each LOW (or after FALL when tl=0), decrement the remaining-period counter; at zero go to IDLE with done=1 for one cycle, otherwise start RISE.
REQ-026 SHALL, with cycles=0, never decrement and repeat periods until stop.
REQ-027 SHALL, on stop=1 while busy, enter IDLE next cycle with level=iv and done=1, regardless of state.
REQ-028 SHALL ignore start while busy; if start and stop are both high in IDLE, stop wins and no burst starts.
REQ-029 SHALL keep done=0 in all other cycles.

Reset
REQ-030 SHALL, on any edge with rst_n=0, set level=0, phase=IDLE, busy=0, done=0, all counters and latched config to 0, overriding start/stop.
REQ-031 SHALL abort a running burst on reset mid-operation without a done pulse; first start after rst_n returns high behaves as from power-up.

Verification
REQ-032 SHALL cover: iv=10, pv=50, rstep=20, fstep=40, td=2, th=3, tl=2, cycles=1 -> DELAY 2 cycles at 10; RISE levels 30,50; HIGH 3 cycles at 50; FALL 10; LOW 2 cycles; done pulse; IDLE at 10.
REQ-033 SHALL cover: iv=250, pv=255, rstep=100, W=8 -> level saturates at 255 after one RISE cycle, no wrap to low values.
REQ-034 SHALL cover: td=0, th=0, tl=0, rstep=0, fstep=0, cycles=3 -> level alternates iv/pv each cycle for 3 periods, then exactly one done.
REQ-035 SHALL cover: cycles=0, stop asserted in HIGH -> next cycle IDLE, level=iv, done=1; start pulses during the burst ignored.
REQ-036 SHALL cover: rst_n=0 for one edge during RISE -> level=0, IDLE, busy=0, no done; new start then runs the full sequence.
REQ-037 SHALL cover: pv=5 < iv=20 -> flat burst at 20 in all states, phase still sequences with correct durations.
